// File: rtl/issue_queue.sv
// issue_queue: 16-entry age-ordered issue queue with wakeup, bypass and 1-cycle registered issue.
// Optional IQ_FLUSH_EN adds a flush input that empties the queue at the next edge.
module issue_queue #(
    parameter int OPCODE_WIDTH = 7,
    parameter int AGE          = 5,
    parameter int TAG          = 6
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef IQ_FLUSH_EN
    input  logic                    flush,
`endif
    input  logic                    disp_valid,
    output logic                    disp_ready,
    input  logic [OPCODE_WIDTH-1:0] disp_op,
    input  logic [TAG-1:0]          disp_src1,
    input  logic [TAG-1:0]          disp_src2,
    input  logic                    disp_src1_rdy,
    input  logic                    disp_src2_rdy,
    input  logic [TAG-1:0]          disp_dst,
    input  logic                    wb_valid,
    input  logic [TAG-1:0]          wb_tag,
    output logic [OPCODE_WIDTH-1:0] iq_op [16],
    output logic [15:0]             iq_req,
    output logic [AGE-1:0]          iq_age [16],
    input  logic                    gnt_valid,
    input  logic [3:0]              gnt_addr,
    output logic                    iss_valid,
    output logic [OPCODE_WIDTH-1:0] iss_op,
    output logic [TAG-1:0]          iss_dst,
    output logic [TAG-1:0]          iss_src1,
    output logic [TAG-1:0]          iss_src2,
    output logic [4:0]              count
);
    logic [15:0]             r_valid, r_src1_rdy, r_src2_rdy;
    logic [OPCODE_WIDTH-1:0] r_op [16];
    logic [TAG-1:0]          r_src1 [16];
    logic [TAG-1:0]          r_src2 [16];
    logic [TAG-1:0]          r_dst [16];
    logic [AGE-1:0]          r_age [16];
    logic [4:0]              r_count;
    logic                    w_flush, w_issue, w_disp;
    logic [3:0]              w_free;
    logic [AGE-1:0]          w_iss_age;

`ifdef IQ_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign iq_req     = r_valid & r_src1_rdy & r_src2_rdy;
    assign iq_op      = r_op;
    assign iq_age     = r_age;
    assign count      = r_count;
    assign disp_ready = ~r_count[4];
    assign w_issue    = gnt_valid & iq_req[gnt_addr];
    assign w_disp     = disp_valid & disp_ready;
    assign w_iss_age  = r_age[gnt_addr];

    // Lowest invalid slot at cycle start; a slot freed by this cycle's issue is still valid here.
    always_comb begin
        w_free = '0;
        for (int i = 15; i >= 0; i--)
            if (!r_valid[i]) w_free = 4'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= '0;
            r_src1_rdy <= '0;
            r_src2_rdy <= '0;
            r_count    <= '0;
            iss_valid  <= 1'b0;
            iss_op     <= '0;
            iss_dst    <= '0;
            iss_src1   <= '0;
            iss_src2   <= '0;
            for (int i = 0; i < 16; i++) begin
                r_op[i]   <= '0;
                r_src1[i] <= '0;
                r_src2[i] <= '0;
                r_dst[i]  <= '0;
                r_age[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (r_valid[i] && wb_valid && r_src1[i] == wb_tag) r_src1_rdy[i] <= 1'b1;
                if (r_valid[i] && wb_valid && r_src2[i] == wb_tag) r_src2_rdy[i] <= 1'b1;
                if (w_issue && r_valid[i] && r_age[i] > w_iss_age) r_age[i] <= r_age[i] - AGE'(1);
            end
            if (w_issue) begin
                r_valid[gnt_addr] <= 1'b0;
                iss_op            <= r_op[gnt_addr];
                iss_dst           <= r_dst[gnt_addr];
                iss_src1          <= r_src1[gnt_addr];
                iss_src2          <= r_src2[gnt_addr];
            end
            if (w_disp) begin
                r_valid[w_free]    <= 1'b1;
                r_op[w_free]       <= disp_op;
                r_src1[w_free]     <= disp_src1;
                r_src2[w_free]     <= disp_src2;
                r_dst[w_free]      <= disp_dst;
                r_src1_rdy[w_free] <= disp_src1_rdy | (wb_valid && disp_src1 == wb_tag);
                r_src2_rdy[w_free] <= disp_src2_rdy | (wb_valid && disp_src2 == wb_tag);
                r_age[w_free]      <= AGE'(r_count - 5'(w_issue));
            end
            r_count   <= r_count + 5'(w_disp) - 5'(w_issue);
            iss_valid <= w_issue & ~w_flush;
            // Flush wins over any concurrent dispatch or issue.
            if (w_flush) begin
                r_valid <= '0;
                r_count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed stimulus with a scoreboard of expected issues checked by a separate monitor.
module tb_issue_queue;
    typedef struct packed {
        logic [6:0] op;
        logic [5:0] dst;
        logic [5:0] s1;
        logic [5:0] s2;
    } iss_t;

    logic       clk = 0, rst = 1;
    logic       disp_valid, disp_ready, disp_src1_rdy, disp_src2_rdy, wb_valid, gnt_valid, iss_valid;
    logic [6:0] disp_op, iss_op;
    logic [5:0] disp_src1, disp_src2, disp_dst, wb_tag, iss_dst, iss_src1, iss_src2;
    logic [6:0] iq_op [16];
    logic [15:0] iq_req;
    logic [4:0] iq_age [16];
    logic [3:0] gnt_addr;
    logic [4:0] count;
`ifdef IQ_FLUSH_EN
    logic       flush = 0;
`endif
    int         checks = 0, errors = 0;
    iss_t       q[$];

    issue_queue dut (
        .clk(clk), .rst(rst),
`ifdef IQ_FLUSH_EN
        .flush(flush),
`endif
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_src1(disp_src1), .disp_src2(disp_src2),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy), .disp_dst(disp_dst),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .iq_op(iq_op), .iq_req(iq_req), .iq_age(iq_age),
        .gnt_valid(gnt_valid), .gnt_addr(gnt_addr),
        .iss_valid(iss_valid), .iss_op(iss_op), .iss_dst(iss_dst),
        .iss_src1(iss_src1), .iss_src2(iss_src2), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every observed issue must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && iss_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL iss_unexpected got op=%0h dst=%0h expected no issue", iss_op, iss_dst);
            end else begin
                iss_t e;
                e = q.pop_front();
                if ({iss_op, iss_dst, iss_src1, iss_src2} !== e) begin
                    errors++;
                    $display("FAIL iss_fields got %0h expected %0h", {iss_op, iss_dst, iss_src1, iss_src2}, e);
                end
            end
        end
    end

    task automatic clear_in();
        disp_valid = 0; disp_op = 0; disp_src1 = 0; disp_src2 = 0;
        disp_src1_rdy = 0; disp_src2_rdy = 0; disp_dst = 0;
        wb_valid = 0; wb_tag = 0; gnt_valid = 0; gnt_addr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic set_disp(input logic [6:0] op, input logic [5:0] dst, input logic [5:0] s1,
                            input logic r1, input logic [5:0] s2, input logic r2);
        disp_valid = 1; disp_op = op; disp_dst = dst;
        disp_src1 = s1; disp_src1_rdy = r1; disp_src2 = s2; disp_src2_rdy = r2;
    endtask

    initial begin
        clear_in();
        #1;
        chk("rst_count", count, 0);
        chk("rst_ready", disp_ready, 1);
        chk("rst_req", iq_req, 0);
        chk("rst_iss", iss_valid, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 0;

        for (int k = 0; k < 3; k++) begin
            set_disp(7'(8'h11 + k), 6'(1 + k), 6'(8'h20 + k), 1, 6'(8'h30 + k), 1);
            tick();
        end
        chk("d3_count", count, 3);
        chk("d3_req", iq_req, 16'h0007);
        chk("d3_age0", iq_age[0], 0);
        chk("d3_age1", iq_age[1], 1);
        chk("d3_age2", iq_age[2], 2);

        gnt_valid = 1; gnt_addr = 1;
        q.push_back('{op: 7'h12, dst: 6'd2, s1: 6'h21, s2: 6'h31});
        tick();
        chk("g1_count", count, 2);
        chk("g1_req", iq_req, 16'h0005);
        chk("g1_age2", iq_age[2], 1);
        chk("g1_age0", iq_age[0], 0);

        set_disp(7'h14, 6'd4, 6'h0B, 0, 6'h05, 1);
        tick();
        chk("nr_count", count, 3);
        chk("nr_age1", iq_age[1], 2);
        chk("nr_req", iq_req, 16'h0005);
        gnt_valid = 1; gnt_addr = 1;
        tick();
        chk("ign_count", count, 3);
        chk("ign_req", iq_req, 16'h0005);
        chk("ign_age1", iq_age[1], 2);

        wb_valid = 1; wb_tag = 6'h0B;
        #1;
        chk("wake_same_cycle", iq_req, 16'h0005);
        tick();
        chk("wake_next_cycle", iq_req, 16'h0007);

        set_disp(7'h15, 6'd5, 6'h0A, 0, 6'h07, 1);
        wb_valid = 1; wb_tag = 6'h0A;
        tick();
        chk("byp_req", iq_req, 16'h000F);
        chk("byp_count", count, 4);
        chk("byp_age3", iq_age[3], 3);

        for (int k = 4; k < 16; k++) begin
            set_disp(7'(8'h40 + k), 6'(k), 6'(k), 1, 6'(k + 16), 1);
            tick();
        end
        chk("full_count", count, 16);
        chk("full_ready", disp_ready, 0);
        chk("full_age15", iq_age[15], 15);

        set_disp(7'h55, 6'd9, 6'd9, 1, 6'd9, 1);
        gnt_valid = 1; gnt_addr = 5;
        q.push_back('{op: 7'h45, dst: 6'd5, s1: 6'd5, s2: 6'd21});
        tick();
        chk("rej_count", count, 15);
        chk("rej_ready", disp_ready, 1);
        chk("rej_age6", iq_age[6], 5);
        chk("rej_age15", iq_age[15], 14);
        set_disp(7'h66, 6'd6, 6'd6, 1, 6'd6, 1);
        tick();
        chk("reuse_count", count, 16);
        chk("reuse_op5", iq_op[5], 7'h66);
        chk("reuse_age5", iq_age[5], 15);

        rst = 1; #1; rst = 0;
        chk("rst1_count", count, 0);
        for (int k = 0; k < 7; k++) begin
            set_disp(7'(8'h70 + k), 6'(k), 6'(k), 1, 6'(k), 1);
            tick();
        end
        chk("d7_count", count, 7);
        chk("d7_req", iq_req, 16'h007F);
        set_disp(7'h7F, 6'd1, 6'd1, 1, 6'd1, 1);
        gnt_valid = 1; gnt_addr = 0;
        #2;
        rst = 1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_req", iq_req, 0);
        chk("arst_ready", disp_ready, 1);
        chk("arst_iss", iss_valid, 0);
        @(posedge clk); #1;
        rst = 0;
        clear_in();
        tick();
        chk("post_rst_count", count, 0);
        chk("post_rst_req", iq_req, 0);

`ifdef IQ_FLUSH_EN
        for (int k = 0; k < 3; k++) begin
            set_disp(7'(8'h10 + k), 6'(k), 6'(k), 1, 6'(k), 1);
            tick();
        end
        set_disp(7'h33, 6'd3, 6'd3, 1, 6'd3, 1);
        gnt_valid = 1; gnt_addr = 0;
        flush = 1;
        tick();
        flush = 0;
        chk("flush_count", count, 0);
        chk("flush_req", iq_req, 0);
        chk("flush_iss", iss_valid, 0);
`endif

        tick();
        tick();
        chk("sb_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter OPCODE_WIDTH, default 7: width of the stored opcode.
REQ-002 Parameter AGE, default 5: width of each entry's age field.
REQ-003 Parameter TAG, default 6: width of the physical register tag.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 disp_valid  in  1  dispatch request.
REQ-007 disp_ready  out  1  queue can accept a dispatch.
REQ-008 disp_op  in  OPCODE_WIDTH  opcode of the dispatched instruction.
REQ-009 disp_src1, disp_src2  in  TAG each  source tags.
REQ-010 disp_src1_rdy, disp_src2_rdy  in  1 each  source operand already available.
REQ-011 disp_dst  in  TAG  destination tag.
REQ-012 wb_valid, wb_tag  in  1, TAG  wakeup broadcast.
REQ-013 iq_op[15:0]  out  OPCODE_WIDTH each  per-entry opcode, fed to the select arbiters.
REQ-014 iq_req[15:0]  out  1 each  per-entry ready-to-issue flag.
REQ-015 iq_age[15:0]  out  AGE each  per-entry age; the smallest value marks the oldest entry.
REQ-016 gnt_valid, gnt_addr  in  1, 4  grant returned by the arbiter.
REQ-017 iss_valid  out  1  registered issue output is valid.
REQ-018 iss_op, iss_dst, iss_src1, iss_src2  out  registered fields of the issued entry.
REQ-019 count  out  5  number of valid entries.

Function
REQ-020 Each of the 16 entries SHALL hold: valid, op, src1, src1_rdy, src2, src2_rdy, dst and age.
REQ-021 iq_req[i] SHALL equal valid[i] & src1_rdy[i] & src2_rdy[i], computed combinationally from the registered state.
REQ-022 disp_ready SHALL be 1 exactly when the registered count is below 16; it SHALL NOT depend on a grant issued in the same cycle.
REQ-023 Accepted dispatch (disp_valid & disp_ready): the lowest-index entry that is invalid at the start of the cycle SHALL be written.
REQ-024 The slot freed by an issue SHALL NOT be reused in the same cycle.
REQ-025 Issue: a grant with gnt_valid=1 and iq_req[gnt_addr]=1 SHALL clear that entry's valid bit.
REQ-026 On an issue, iss_valid SHALL be 1 in the next cycle, with iss_op/iss_dst/iss_src1/iss_src2 carrying the issued entry's fields (1-cycle latency).
REQ-027 A grant to an entry whose iq_req is 0 SHALL be ignored: no dequeue and iss_valid=0.
REQ-028 Age compaction: on an issue of age A, every remaining valid entry with age greater than A SHALL decrement its age by 1 in the same edge.
REQ-029 A dispatched entry's age SHALL equal the post-issue count of previously valid entries, so ages are always unique and contiguous 0..count-1.
REQ-030 Wakeup: when wb_valid=1, every valid entry whose src1 or src2 equals wb_tag SHALL set the matching rdy bit.
REQ-031 A dispatched entry whose source tag equals wb_tag in the same cycle SHALL be written with that rdy bit set (bypass).
REQ-032 An entry woken in cycle N SHALL assert iq_req in cycle N+1 and SHALL NOT assert it in cycle N.
REQ-033 count SHALL update as count + dispatch − issue; simultaneous dispatch and issue SHALL leave count unchanged.
REQ-034 Fields of invalid entries SHALL be don't-care, except that their iq_req SHALL be 0.

Reset
REQ-035 Asserting rst SHALL immediately clear all valid bits and set count=0, iss_valid=0, all iq_req=0 and disp_ready=1.
REQ-036 Asserting rst mid-operation SHALL discard every in-flight dispatch and issue; no entry survives.
REQ-037 All ages and rdy bits SHALL reset to 0.

Configuration
REQ-038 Macro IQ_FLUSH_EN defined: an input port flush (1 bit) SHALL exist; flush=1 SHALL clear all valid bits and set count=0 at the next edge, take priority over a simultaneous dispatch and issue, and force iss_valid=0 in the next cycle.
REQ-039 Macro IQ_FLUSH_EN undefined: the flush port SHALL be absent and behaviour SHALL be as in REQ-020 to REQ-037.

Verification
REQ-040 Scenario: after reset, dispatch 3 ready ops in 3 cycles -> entries 0,1,2 with ages 0,1,2, count=3, iq_req=0x0007.
REQ-041 Scenario: grant addr 1 from the previous state -> next cycle iss_valid=1 with entry 1's fields, entry 2 age becomes 1, count=2.
REQ-042 Scenario: fill 16 entries -> disp_ready=0; dispatch and grant addr 5 in the same cycle -> dispatch rejected, count=15, slot 5 is written by the next dispatch with age 15.
REQ-043 Scenario: dispatch with src1=0x0A, src1_rdy=0 while wb_tag=0x0A and wb_valid=1 in the same cycle -> entry stored ready, iq_req=1 next cycle; a later wakeup of a stored entry -> iq_req rises exactly one cycle after wb_valid.
REQ-044 Scenario: gnt_valid=1 to a non-ready entry -> no state change, iss_valid=0.
REQ-045 Scenario: rst pulsed while count=7 -> count=0 and iq_req=0 asynchronously; with IQ_FLUSH_EN, flush with a concurrent dispatch -> count=0.
